// File: rtl/aes192_inv_key_sched.sv
// Sequential AES-192 key scheduler: expands forward, then walks back emitting round keys 12..0.
// Optional build macro AES_EQINV_KEY_EN applies InvMixColumns to round keys 1..11 (equivalent inverse cipher).
module aes192_inv_key_sched #(
    parameter int NR = 12,
    parameter int NK = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [191:0] key,
    input  logic         flush,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk,
    output logic [3:0]   rk_round,
    output logic         rk_last
);

    if (NR != 12 || NK != 6) begin : g_bad_cfg
        $error("aes192_inv_key_sched supports only NR=12 and NK=6");
    end

    typedef enum logic [1:0] {IDLE, FWD, OUT, BACK} state_t;

    localparam logic [255:0][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Byte x sits at packed index 255-x because the table literal lists byte 0 first.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[~x];
    endfunction

    state_t           state, state_nx;
    logic [5:0][31:0] win;
    logic [5:0]       idx;
    logic [3:0]       rnd;
    logic [127:0]     rk_q;
    logic             rk_valid_q;

    logic             fwd, key_fire, rk_fire, lo_hit;
    logic [5:0]       pos, pos_div;
    logic [7:0]       rcon;
    logic [31:0]      sub_in, rot_sub, mix, base, new_word;

    // idx is the next word index i in FWD and the window base lo in BACK.
    assign fwd      = (state == FWD);
    assign pos      = fwd ? idx : idx + 6'd5;
    assign pos_div  = pos / 6'd6;
    assign rcon     = 8'h01 << (pos_div - 6'd1);
    assign sub_in   = fwd ? win[5] : win[4];
    assign rot_sub  = {sbox(sub_in[23:16]), sbox(sub_in[15:8]), sbox(sub_in[7:0]), sbox(sub_in[31:24])};
    assign mix      = (pos % 6'd6 == 6'd0) ? (rot_sub ^ {rcon, 24'h0}) : sub_in;
    assign base     = fwd ? win[0] : win[5];
    assign new_word = base ^ mix;

    assign key_fire = (state == IDLE) && key_valid && !flush;
    assign rk_fire  = (state == OUT) && rk_valid_q && rk_ready;
    assign lo_hit   = ((idx - 6'd1) == {rnd, 2'b00});

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (key_fire) state_nx = FWD;
            FWD:     if (idx == 6'd51) state_nx = OUT;
            OUT:     if (rk_fire) state_nx = (rnd == 4'd0) ? IDLE : BACK;
            BACK:    if (lo_hit) state_nx = OUT;
            default: state_nx = IDLE;
        endcase
        if (flush) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // NOTE: the window is six flops, not a RAM, so clearing it under reset costs nothing special.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win        <= '0;
            idx        <= '0;
            rnd        <= '0;
            rk_q       <= '0;
            rk_valid_q <= 1'b0;
        end else if (flush) begin
            rk_valid_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (key_valid) begin
                    win <= {key[31:0], key[63:32], key[95:64], key[127:96], key[159:128], key[191:160]};
                    idx <= 6'd6;
                    rnd <= 4'd0;
                end
                FWD: begin
                    win <= {new_word, win[5:1]};
                    if (idx == 6'd51) begin
                        idx <= 6'd46;
                        rnd <= 4'd12;
                    end else begin
                        idx <= idx + 6'd1;
                    end
                end
                OUT: begin
                    if (!rk_valid_q) begin
                        rk_valid_q <= 1'b1;
                        rk_q <= (rnd == 4'd12) ? {win[2], win[3], win[4], win[5]}
                                               : {win[0], win[1], win[2], win[3]};
                    end else if (rk_ready) begin
                        rk_valid_q <= 1'b0;
                        if (rnd != 4'd0) rnd <= rnd - 4'd1;
                    end
                end
                BACK: begin
                    win <= {win[4:0], new_word};
                    idx <= idx - 6'd1;
                end
                default: ;
            endcase
        end
    end

    assign key_ready = (state == IDLE);
    assign rk_valid  = rk_valid_q;
    assign rk_round  = rnd;
    assign rk_last   = rk_valid_q && (rnd == 4'd0);

`ifdef AES_EQINV_KEY_EN
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] m11 [4];
        logic [7:0] m13 [4];
        logic [7:0] m14 [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]   = c[31 - 8*i -: 8];
            x2     = xt(a[i]);
            x4     = xt(x2);
            x8     = xt(x4);
            m9[i]  = x8 ^ a[i];
            m11[i] = x8 ^ x2 ^ a[i];
            m13[i] = x8 ^ x4 ^ a[i];
            m14[i] = x8 ^ x4 ^ x2;
        end
        return {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
                m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
                m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
                m11[0] ^ m13[1] ^ m9[2]  ^ m14[3]};
    endfunction

    assign rk = (rnd != 4'd0 && rnd != 4'd12)
              ? {inv_mix_col(rk_q[127:96]), inv_mix_col(rk_q[95:64]),
                 inv_mix_col(rk_q[63:32]),  inv_mix_col(rk_q[31:0])}
              : rk_q;
`else
    assign rk = rk_q;
`endif

endmodule

// File: tb/tb_aes192_inv_key_sched.sv
// Directed bench for aes192_inv_key_sched: FIPS-197 vectors, stalls, flush, reset and latency.
// Expected round keys come from a key-expansion model whose S-box is derived from GF(2^8) arithmetic.
`timescale 1ns/1ps
module tb_aes192_inv_key_sched;

    localparam logic [191:0] KEY_A2 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [191:0] KEY_C2 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         key_valid;
    logic         key_ready;
    logic [191:0] key;
    logic         flush;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk;
    logic [3:0]   rk_round;
    logic         rk_last;

    int           n_assert = 0;
    int           n_fail   = 0;
    logic [7:0]   sb [256];
    logic [31:0]  ew [52];
    logic [127:0] first_rk, last_rk;

    aes192_inv_key_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key       (key),
        .flush     (flush),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .rk        (rk),
        .rk_round  (rk_round),
        .rk_last   (rk_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    task automatic build_sbox();
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sb[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                        ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    task automatic expand(input logic [191:0] k);
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 6; i++) ew[i] = k[191 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 6; i < 52; i++) begin
            t = ew[i-1];
            if (i % 6 == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            ew[i] = ew[i-6] ^ t;
        end
    endtask

`ifdef AES_EQINV_KEY_EN
    function automatic logic [31:0] imc_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {gmul(a0, 8'd14) ^ gmul(a1, 8'd11) ^ gmul(a2, 8'd13) ^ gmul(a3, 8'd9),
                gmul(a0, 8'd9)  ^ gmul(a1, 8'd14) ^ gmul(a2, 8'd11) ^ gmul(a3, 8'd13),
                gmul(a0, 8'd13) ^ gmul(a1, 8'd9)  ^ gmul(a2, 8'd14) ^ gmul(a3, 8'd11),
                gmul(a0, 8'd11) ^ gmul(a1, 8'd13) ^ gmul(a2, 8'd9)  ^ gmul(a3, 8'd14)};
    endfunction
`endif

    function automatic logic [127:0] exp_rk(input int r);
        logic [127:0] v;
        v = {ew[4*r], ew[4*r+1], ew[4*r+2], ew[4*r+3]};
`ifdef AES_EQINV_KEY_EN
        if (r >= 1 && r <= 11)
            v = {imc_col(v[127:96]), imc_col(v[95:64]), imc_col(v[63:32]), imc_col(v[31:0])};
`endif
        return v;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_key_ready"}, key_ready, 1);
        check({tag, "_rk_valid"},  rk_valid,  0);
        check({tag, "_rk"},        rk,        0);
        check({tag, "_rk_round"},  rk_round,  0);
        check({tag, "_rk_last"},   rk_last,   0);
    endtask

    // Entered and left on a falling edge with the DUT idle; rnd_ready draws rk_ready at random.
    task automatic run_key(input logic [191:0] k, input bit rnd_ready);
        int got, n, since, lat, r;
        expand(k);
        got = 0;
        n   = 0;
        key = k;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        since = 0;
        while (got < 13 && n < 4000) begin
            if (rk_valid) begin
                r = 12 - got;
                check($sformatf("rk_r%0d", r), rk, exp_rk(r));
                check($sformatf("rk_round_r%0d", r), rk_round, r);
                check($sformatf("rk_last_r%0d", r), rk_last, (r == 0));
                if (!rnd_ready && since >= 0) begin
                    lat = (got == 0) ? 47 : ((got == 1) ? 3 : 5);
                    check($sformatf("latency_r%0d", r), since, lat);
                end
                if (got == 0) first_rk = rk;
                if (r == 0) last_rk = rk;
                rk_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                if (rk_ready) begin
                    got++;
                    since = -1;
                end else begin
                    since = -100000;
                end
            end else if (rnd_ready) begin
                rk_ready = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            since++;
            n++;
        end
        check("all_13_keys_seen", got, 13);
        check("idle_after_r0", key_ready, 1);
        rk_ready = 1'b1;
    endtask

    initial begin
        int  n;
        bit  saw;
        rst_n = 1'b1;
        key_valid = 1'b0;
        key = '0;
        flush = 1'b0;
        rk_ready = 1'b0;
        first_rk = '0;
        last_rk = '0;
        build_sbox();
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("after_reset");

        // FIPS-197 A.2 key with the consumer always ready.
        rk_ready = 1'b1;
        run_key(KEY_A2, 1'b0);
        check("a2_r12_vector", first_rk, 128'he98ba06f448c773c8ecc720401002202);
        check("a2_r0_vector",  last_rk,  128'h8e73b0f7da0e6452c810f32b809079e5);

        // C.2 key issued back-to-back on the cycle after the previous r=0 handshake.
        run_key(KEY_C2, 1'b0);
        check("c2_r12_vector", first_rk, 128'ha4970a331a78dc09c418c271e3a41d5d);
        check("c2_r0_vector",  last_rk,  128'h000102030405060708090a0b0c0d0e0f);

        // Random back-pressure: every valid cycle re-checked against the model.
        run_key(KEY_A2, 1'b1);
        check("rand_a2_r12", first_rk, 128'he98ba06f448c773c8ecc720401002202);

        // Flush during forward expansion.
        key = KEY_C2;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        repeat (19) @(negedge clk);
        check("fwd_busy_key_ready", key_ready, 0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_fwd_key_ready", key_ready, 1);
        check("flush_fwd_rk_valid", rk_valid, 0);
        run_key(KEY_A2, 1'b0);
        check("post_flush_r12", first_rk, 128'he98ba06f448c773c8ecc720401002202);

        // Flush while stalled on r=7, with a handshake offered in the same cycle.
        expand(KEY_C2);
        key = KEY_C2;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        n = 0;
        while (!(rk_valid && rk_round == 4'd7) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("reach_r7", {rk_valid, rk_round}, {1'b1, 4'd7});
        rk_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("stall_r7_valid", rk_valid, 1);
        check("stall_r7_rk", rk, exp_rk(7));
        check("stall_r7_round", rk_round, 7);
        flush = 1'b1;
        rk_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_out_rk_valid", rk_valid, 0);
        check("flush_out_key_ready", key_ready, 1);

        // key_valid together with flush in IDLE must not start a schedule.
        key = KEY_A2;
        key_valid = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        flush = 1'b0;
        saw = 1'b0;
        repeat (60) begin
            if (rk_valid || !key_ready) saw = 1'b1;
            @(negedge clk);
        end
        check("flush_blocks_key", saw, 0);

        // key_valid during FWD is ignored; then reset pulse while walking backward.
        expand(KEY_C2);
        key = KEY_C2;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("fwd_key_ready_low", key_ready, 0);
        key = KEY_A2;
        key_valid = 1'b1;
        repeat (3) @(negedge clk);
        key_valid = 1'b0;
        key = KEY_C2;
        n = 0;
        while (!rk_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("ignored_key_r12", rk, exp_rk(12));
        @(negedge clk);
        check("in_back_round", {rk_valid, rk_round}, {1'b0, 4'd11});
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_key(KEY_C2, 1'b0);
        check("post_reset_r12", first_rk, 128'ha4970a331a78dc09c418c271e3a41d5d);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
